// File: rtl/next_pc_unit_if.sv
// Interface between the hazard control unit / branch resolution and the
// next-PC unit. The master drives PC selection and BTB updates; the slave
// (next_pc_unit) returns the fetch PC, prediction and status.
interface next_pc_unit_if;
    logic        pcen;
    logic [2:0]  pcselect;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] rpc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        sel_err;
    logic [15:0] mispred_cnt;

    modport master (
        output pcen, pcselect, bpc, jpc, rpc,
        output upd_en, upd_pc, upd_taken, upd_target,
        input  pc, pred_hit, pred_taken, pred_target, sel_err, mispred_cnt
    );

    modport slave (
        input  pcen, pcselect, bpc, jpc, rpc,
        input  upd_en, upd_pc, upd_taken, upd_target,
        output pc, pred_hit, pred_taken, pred_target, sel_err, mispred_cnt
    );
endinterface

// File: rtl/next_pc_unit.sv
// Fetch PC register with next-PC selection and a direct-mapped BTB holding a
// 2-bit saturating direction counter and a target per entry.
module next_pc_unit #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 8
) (
    input  logic           CLK,
    input  logic           RST,
    next_pc_unit_if.slave  bus
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // pcselect_t encoding
    localparam logic [2:0] PCNPC    = 3'd0;
    localparam logic [2:0] PCBPC    = 3'd1;
    localparam logic [2:0] PCJPC    = 3'd2;
    localparam logic [2:0] PCPTA    = 3'd3;
    localparam logic [2:0] PRBPC    = 3'd4;
    localparam logic [2:0] PRMPC    = 3'd5;
    localparam logic [2:0] PCERROR6 = 3'd6;
    localparam logic [2:0] PCERROR7 = 3'd7;

    logic [31:0] pc_q;
    logic        sel_err_q;
    logic [15:0] cnt_q;
    logic [31:0] pc_plus4;
    logic [31:0] npc;
    logic        is_err;
    logic        is_recov;

    logic             btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
    logic [31:0]      btb_target [BTB_ENTRIES];
    logic [1:0]       btb_ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             hit;

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [1:0]       u_ctr_inc;
    logic [1:0]       u_ctr_dec;

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{pc_q[1:0], bus.upd_pc[1:0]};

    // Lookup always sees the registered (pre-update) BTB contents.
    assign look_idx = pc_q[IDX_W+1:2];
    assign look_tag = pc_q[31:IDX_W+2];
    assign hit      = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);

    assign bus.pc          = pc_q;
    assign bus.pred_hit    = hit;
    assign bus.pred_taken  = hit && btb_ctr[look_idx][1];
    assign bus.pred_target = hit ? btb_target[look_idx] : 32'h0;
    assign bus.sel_err     = sel_err_q;
    assign bus.mispred_cnt = cnt_q;

    assign pc_plus4 = pc_q + 32'd4;
    assign is_err   = (bus.pcselect == PCERROR6) || (bus.pcselect == PCERROR7);
    assign is_recov = (bus.pcselect == PRBPC) || (bus.pcselect == PRMPC);

    // Next-PC mux; illegal selects hold the current PC.
    always_comb begin
        npc = pc_q;
        case (bus.pcselect)
            PCNPC:   npc = pc_plus4;
            PCBPC:   npc = bus.bpc;
            PCJPC:   npc = bus.jpc;
            PCPTA:   npc = hit ? btb_target[look_idx] : pc_plus4;
            PRBPC:   npc = bus.bpc;
            PRMPC:   npc = bus.rpc;
            default: npc = pc_q;
        endcase
    end

    // PC, sticky illegal-select flag and saturating recovery counter; all frozen on stall.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q      <= PC_RESET;
            sel_err_q <= 1'b0;
            cnt_q     <= 16'h0;
        end else if (bus.pcen) begin
            pc_q <= npc;
            if (is_err)
                sel_err_q <= 1'b1;
            if (is_recov && (cnt_q != 16'hFFFF))
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign u_idx     = bus.upd_pc[IDX_W+1:2];
    assign u_tag     = bus.upd_pc[31:IDX_W+2];
    assign u_hit     = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
    assign u_ctr_inc = (btb_ctr[u_idx] == 2'b11) ? 2'b11 : btb_ctr[u_idx] + 2'd1;
    assign u_ctr_dec = (btb_ctr[u_idx] == 2'b00) ? 2'b00 : btb_ctr[u_idx] - 2'd1;

    // BTB training: hits move the counter, taken misses allocate weakly-taken,
    // not-taken misses leave the entry alone. Independent of pcen/pcselect.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= 32'h0;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (bus.upd_en) begin
            if (u_hit) begin
                if (bus.upd_taken) begin
                    btb_ctr[u_idx]    <= u_ctr_inc;
                    btb_target[u_idx] <= bus.upd_target;
                end else begin
                    btb_ctr[u_idx] <= u_ctr_dec;
                end
            end else if (bus.upd_taken) begin
                btb_valid[u_idx]  <= 1'b1;
                btb_tag[u_idx]    <= u_tag;
                btb_target[u_idx] <= bus.upd_target;
                btb_ctr[u_idx]    <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: reset, sequential fetch, stall/wrap,
// BTB training, recovery, illegal selects, mid-run reset and aliasing.
module tb_next_pc_unit;
    localparam logic [2:0] PCNPC = 3'd0, PCBPC = 3'd1, PCJPC = 3'd2, PCPTA = 3'd3,
                           PRBPC = 3'd4, PRMPC = 3'd5, PCERR6 = 3'd6, PCERR7 = 3'd7;

    logic CLK = 1'b0;
    logic RST;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    next_pc_unit_if bus();

    next_pc_unit #(.PC_RESET(32'h0000_0040), .BTB_ENTRIES(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.pcen = 1'b0; bus.pcselect = PCNPC;
        bus.bpc = 32'h0; bus.jpc = 32'h0; bus.rpc = 32'h0;
        bus.upd_en = 1'b0; bus.upd_pc = 32'h0; bus.upd_taken = 1'b0; bus.upd_target = 32'h0;
        #12;
        n_checks++; if (bus.pc !== 32'h40) begin n_fail++; $display("FAIL rst_pc got %h exp %h", bus.pc, 32'h40); end
        n_checks++; if (bus.pred_hit !== 1'b0) begin n_fail++; $display("FAIL rst_hit got %b exp 0", bus.pred_hit); end
        n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken got %b exp 0", bus.pred_taken); end
        n_checks++; if (bus.pred_target !== 32'h0) begin n_fail++; $display("FAIL rst_target got %h exp 0", bus.pred_target); end
        n_checks++; if (bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL rst_selerr got %b exp 0", bus.sel_err); end
        n_checks++; if (bus.mispred_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_cnt got %h exp 0", bus.mispred_cnt); end
        step();
        RST = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        bus.pcen = 1'b1; bus.pcselect = PCNPC;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_pc = 32'h40 + 32'(4 * i);
            n_checks++; if (bus.pc !== exp_pc) begin n_fail++; $display("FAIL seq_pc%0d got %h exp %h", i, bus.pc, exp_pc); end
            n_checks++; if (bus.pred_hit !== 1'b0) begin n_fail++; $display("FAIL seq_hit%0d got %b exp 0", i, bus.pred_hit); end
        end
    endtask

    task automatic test_stall_wrap();
        bus.pcen = 1'b0; bus.pcselect = PCJPC; bus.jpc = 32'h100;
        step();
        n_checks++; if (bus.pc !== 32'h4C) begin n_fail++; $display("FAIL stall_pc got %h exp %h", bus.pc, 32'h4C); end
        bus.pcen = 1'b1;
        step();
        n_checks++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL jump_pc got %h exp %h", bus.pc, 32'h100); end
        bus.jpc = 32'hFFFF_FFFC;
        step();
        n_checks++; if (bus.pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL jump_top got %h exp %h", bus.pc, 32'hFFFF_FFFC); end
        bus.pcselect = PCNPC;
        step();
        n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h exp 0", bus.pc); end
    endtask

    task automatic test_branch_train();
        bus.pcen = 1'b1; bus.pcselect = PCJPC; bus.jpc = 32'h100;
        bus.upd_en = 1'b1; bus.upd_pc = 32'h100; bus.upd_taken = 1'b1; bus.upd_target = 32'h200;
        step();
        bus.upd_en = 1'b0;
        n_checks++; if (bus.pred_hit !== 1'b1) begin n_fail++; $display("FAIL train_hit got %b exp 1", bus.pred_hit); end
        n_checks++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_taken got %b exp 1", bus.pred_taken); end
        n_checks++; if (bus.pred_target !== 32'h200) begin n_fail++; $display("FAIL train_target got %h exp %h", bus.pred_target, 32'h200); end
        bus.pcselect = PCPTA;
        step();
        n_checks++; if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL pta_pc got %h exp %h", bus.pc, 32'h200); end
        // two not-taken updates: 10 -> 01 -> 00
        bus.pcen = 1'b0; bus.upd_en = 1'b1; bus.upd_taken = 1'b0;
        step();
        step();
        bus.upd_en = 1'b0;
        bus.pcen = 1'b1; bus.pcselect = PCJPC;
        step();
        n_checks++; if (bus.pred_hit !== 1'b1) begin n_fail++; $display("FAIL nt_hit got %b exp 1", bus.pred_hit); end
        n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt_taken got %b exp 0", bus.pred_taken); end
        // PTA follows the hit target even when predicted not-taken
        bus.pcselect = PCPTA;
        step();
        n_checks++; if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL pta_nt_pc got %h exp %h", bus.pc, 32'h200); end
        // same-cycle lookup sees old counter: 00 -> 01 -> 10
        bus.pcselect = PCJPC;
        step();
        bus.pcen = 1'b0; bus.upd_en = 1'b1; bus.upd_taken = 1'b1;
        step();
        n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL same_cyc_old got %b exp 0", bus.pred_taken); end
        step();
        bus.upd_en = 1'b0;
        n_checks++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL same_cyc_new got %b exp 1", bus.pred_taken); end
    endtask

    task automatic test_recovery();
        bus.pcen = 1'b1; bus.pcselect = PRMPC; bus.rpc = 32'h104;
        step();
        n_checks++; if (bus.pc !== 32'h104) begin n_fail++; $display("FAIL prm_pc got %h exp %h", bus.pc, 32'h104); end
        n_checks++; if (bus.mispred_cnt !== 16'd1) begin n_fail++; $display("FAIL prm_cnt got %0d exp 1", bus.mispred_cnt); end
        bus.pcselect = PRBPC; bus.bpc = 32'h300;
        step();
        n_checks++; if (bus.pc !== 32'h300) begin n_fail++; $display("FAIL prb_pc got %h exp %h", bus.pc, 32'h300); end
        n_checks++; if (bus.mispred_cnt !== 16'd2) begin n_fail++; $display("FAIL prb_cnt got %0d exp 2", bus.mispred_cnt); end
        bus.pcen = 1'b0; bus.pcselect = PRMPC;
        step();
        n_checks++; if (bus.pc !== 32'h300) begin n_fail++; $display("FAIL prstall_pc got %h exp %h", bus.pc, 32'h300); end
        n_checks++; if (bus.mispred_cnt !== 16'd2) begin n_fail++; $display("FAIL prstall_cnt got %0d exp 2", bus.mispred_cnt); end
    endtask

    task automatic test_illegal();
        bus.pcen = 1'b0; bus.pcselect = PCERR6;
        step();
        n_checks++; if (bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL err_stall got %b exp 0", bus.sel_err); end
        bus.pcen = 1'b1; bus.pcselect = PCERR7;
        step();
        n_checks++; if (bus.pc !== 32'h300) begin n_fail++; $display("FAIL err7_pc got %h exp %h", bus.pc, 32'h300); end
        n_checks++; if (bus.sel_err !== 1'b1) begin n_fail++; $display("FAIL err7_flag got %b exp 1", bus.sel_err); end
        bus.pcselect = PCNPC;
        step();
        n_checks++; if (bus.pc !== 32'h304) begin n_fail++; $display("FAIL err_after_pc got %h exp %h", bus.pc, 32'h304); end
        n_checks++; if (bus.sel_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", bus.sel_err); end
        bus.pcselect = PCERR6;
        step();
        n_checks++; if (bus.pc !== 32'h304) begin n_fail++; $display("FAIL err6_pc got %h exp %h", bus.pc, 32'h304); end
    endtask

    task automatic test_reset_mid();
        bus.pcen = 1'b0;
        bus.upd_en = 1'b1; bus.upd_pc = 32'h140; bus.upd_taken = 1'b1; bus.upd_target = 32'h700;
        RST = 1'b1;
        step();
        RST = 1'b0; bus.upd_en = 1'b0;
        n_checks++; if (bus.pc !== 32'h40) begin n_fail++; $display("FAIL mid_pc got %h exp %h", bus.pc, 32'h40); end
        n_checks++; if (bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL mid_selerr got %b exp 0", bus.sel_err); end
        n_checks++; if (bus.mispred_cnt !== 16'h0) begin n_fail++; $display("FAIL mid_cnt got %h exp 0", bus.mispred_cnt); end
        bus.pcen = 1'b1; bus.pcselect = PCJPC; bus.jpc = 32'h140;
        step();
        n_checks++; if (bus.pred_hit !== 1'b0) begin n_fail++; $display("FAIL mid_upd_dropped got %b exp 0", bus.pred_hit); end
        bus.jpc = 32'h100;
        step();
        n_checks++; if (bus.pred_hit !== 1'b0) begin n_fail++; $display("FAIL mid_btb_clr got %b exp 0", bus.pred_hit); end
    endtask

    task automatic test_alias();
        bus.pcen = 1'b0;
        bus.upd_en = 1'b1; bus.upd_pc = 32'h100; bus.upd_taken = 1'b1; bus.upd_target = 32'h200;
        step();
        bus.upd_pc = 32'h120; bus.upd_target = 32'h500;
        step();
        bus.upd_en = 1'b0;
        bus.pcen = 1'b1; bus.pcselect = PCJPC; bus.jpc = 32'h100;
        step();
        n_checks++; if (bus.pred_hit !== 1'b0) begin n_fail++; $display("FAIL alias_hit got %b exp 0", bus.pred_hit); end
        n_checks++; if (bus.pred_target !== 32'h0) begin n_fail++; $display("FAIL alias_target got %h exp 0", bus.pred_target); end
        bus.pcselect = PCPTA;
        step();
        n_checks++; if (bus.pc !== 32'h104) begin n_fail++; $display("FAIL alias_pta got %h exp %h", bus.pc, 32'h104); end
        bus.pcselect = PCJPC; bus.jpc = 32'h120;
        step();
        n_checks++; if (bus.pred_hit !== 1'b1) begin n_fail++; $display("FAIL alias_new_hit got %b exp 1", bus.pred_hit); end
        n_checks++; if (bus.pred_target !== 32'h500) begin n_fail++; $display("FAIL alias_new_target got %h exp %h", bus.pred_target, 32'h500); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_wrap();
        test_branch_train();
        test_recovery();
        test_illegal();
        test_reset_mid();
        test_alias();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
